// File: rtl/ippcrc_pkg.sv
// Shared definitions for the CRC-32 frame sequencer and its datapath cores.
// The CRC register is kept in reflected (Ethernet) bit order, so the first wire bit enters at bit 0.
package ippcrc_pkg;

    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    // Polynomial 04C11DB7 with its bits reversed, matching the reflected register order.
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam int          TAIL_IDX_W      = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TAIL = 2'd2
    } ctl_state_t;

    function automatic logic [31:0] crc32_bit(input logic [31:0] c, input logic d);
        logic fb;
        fb = c[0] ^ d;
        return {1'b0, c[31:1]} ^ (fb ? CRC32_POLY_REFL : 32'h0);
    endfunction

endpackage

// File: rtl/ippcrc_crc32_24b.sv
// Combinational CRC-32 update over 24 data bits; di[0] is processed first.
module ippcrc_crc32_24b
    import ippcrc_pkg::*;
(
    input  logic [31:0] ci,
    input  logic [23:0] di,
    output logic [31:0] co
);

    always_comb begin
        co = ci;
        for (int i = 0; i < 24; i++) begin
            co = crc32_bit(co, di[i]);
        end
    end

endmodule

// File: rtl/ippcrc_crc32_8b.sv
// Combinational CRC-32 update over one byte; di[0] is processed first.
module ippcrc_crc32_8b
    import ippcrc_pkg::*;
(
    input  logic [31:0] ci,
    input  logic [7:0]  di,
    output logic [31:0] co
);

    always_comb begin
        co = ci;
        for (int i = 0; i < 8; i++) begin
            co = crc32_bit(co, di[i]);
        end
    end

endmodule

// File: rtl/ippcrc_crc32_ctl.sv
// Frame sequencer: full 3-byte words through the 24-bit core, a 1/2-byte tail byte-serially.
// Optional frame byte counter on out_len is built when IPPCRC_CTL_LEN_CNT_EN is defined.
module ippcrc_crc32_ctl
    import ippcrc_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [1:0]       in_nb,
    input  logic [23:0]      in_dat,
    input  logic [31:0]      cfg_init,
    input  logic             cfg_inv,
    output logic             out_vld,
    output logic [31:0]      out_crc,
    output logic [LEN_W-1:0] out_len,
    output logic             out_err,
    output logic [1:0]       dbg_state
);

    // Handshake: a word transfers on a rising clk edge where in_vld and in_rdy are both high;
    // in_rdy depends only on state, never on in_vld.

    ctl_state_t            state, state_nxt;
    logic [31:0]           crc_reg, ci, co24, co8;
    logic [15:0]           tail_dat;
    logic [1:0]            tail_nb;
    logic [TAIL_IDX_W-1:0] tail_idx;
    logic [7:0]            tail_byte;
    logic                  inv_q, inv_cur;
    logic [1:0]            nb_eff;
    logic                  accept, is_frame, is_err, eop_full, eop_tail;
    logic                  tail_last, tail_done;

    assign dbg_state = state;

    ippcrc_crc32_24b u_core24 (.ci(ci),      .di(in_dat),    .co(co24));
    ippcrc_crc32_8b  u_core8  (.ci(crc_reg), .di(tail_byte), .co(co8));

    always_comb begin
        in_rdy    = (state != TAIL);
        accept    = in_vld & in_rdy;
        nb_eff    = (in_nb == 2'd0) ? 2'd3 : in_nb;
        ci        = in_sop ? cfg_init : crc_reg;
        inv_cur   = in_sop ? cfg_inv : inv_q;
        is_frame  = accept & (in_sop | (state == RUN));
        // Stray word outside a frame, or a new SOP that aborts the running frame.
        is_err    = accept & (in_sop ? (state == RUN) : (state == IDLE));
        eop_full  = is_frame & in_eop & (nb_eff == 2'd3);
        eop_tail  = is_frame & in_eop & (nb_eff != 2'd3);
        tail_byte = tail_dat[8*tail_idx +: 8];
        tail_last = (({1'b0, tail_idx} + 2'd1) == tail_nb);
        tail_done = (state == TAIL) & tail_last;

        state_nxt = state;
        case (state)
            IDLE, RUN: begin
                if (is_frame) begin
                    if (!in_eop)       state_nxt = RUN;
                    else if (eop_tail) state_nxt = TAIL;
                    else               state_nxt = IDLE;
                end
            end
            TAIL: begin
                if (tail_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg  <= '0;
            tail_dat <= '0;
            tail_nb  <= '0;
            tail_idx <= '0;
            inv_q    <= 1'b0;
            out_vld  <= 1'b0;
            out_crc  <= '0;
            out_err  <= 1'b0;
        end else begin
            out_vld <= eop_full | tail_done;
            out_err <= is_err;
            if (is_frame && in_sop) inv_q <= cfg_inv;
            if (is_frame && !in_eop) crc_reg <= co24;
            // The tail starts from the word's core input, then folds one byte per cycle.
            if (eop_tail) begin
                crc_reg  <= ci;
                tail_dat <= in_dat[15:0];
                tail_nb  <= nb_eff;
                tail_idx <= '0;
            end
            if (state == TAIL) begin
                crc_reg  <= co8;
                tail_idx <= tail_idx + 1'b1;
            end
            if (eop_full)       out_crc <= inv_cur ? ~co24 : co24;
            else if (tail_done) out_crc <= inv_q ? ~co8 : co8;
        end
    end

`ifdef IPPCRC_CTL_LEN_CNT_EN
    logic [LEN_W-1:0] len_cnt, len_q, len_sat;
    logic [LEN_W:0]   len_sum;

    always_comb begin
        len_sum = (in_sop ? {(LEN_W+1){1'b0}} : {1'b0, len_cnt})
                + (LEN_W+1)'(in_eop ? nb_eff : 2'd3);
        len_sat = len_sum[LEN_W] ? {LEN_W{1'b1}} : len_sum[LEN_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
            len_q   <= '0;
        end else begin
            if (is_frame) len_cnt <= len_sat;
            if (eop_full)       len_q <= len_sat;
            else if (tail_done) len_q <= len_cnt;
        end
    end

    assign out_len = len_q;
`else
    assign out_len = '0;
`endif

endmodule

// File: tb/tb_ippcrc_crc32_ctl.sv
// Bench for ippcrc_crc32_ctl: table-driven bytewise CRC-32 model, scoreboard queues and a monitor.
module tb_ippcrc_crc32_ctl;
    import ippcrc_pkg::*;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0, cfg_inv = 1'b0;
    logic [1:0]       in_nb = '0;
    logic [23:0]      in_dat = '0;
    logic [31:0]      cfg_init = '0;
    logic             in_rdy, out_vld, out_err;
    logic [31:0]      out_crc;
    logic [LEN_W-1:0] out_len;
    logic [1:0]       dbg_state;

    ippcrc_crc32_ctl #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_sop(in_sop),
        .in_eop(in_eop), .in_nb(in_nb), .in_dat(in_dat), .cfg_init(cfg_init), .cfg_inv(cfg_inv),
        .out_vld(out_vld), .out_crc(out_crc), .out_len(out_len), .out_err(out_err),
        .dbg_state(dbg_state)
    );

    // Clock / cycle counter / watchdog
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 40000) begin
            $display("FAIL watchdog: cycle %0d exceeded, required < 40000", cyc);
            $fatal(1, "watchdog");
        end
    end

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: standard byte-table CRC-32 over the frame's byte list
    logic [31:0] crc_tab [256];
    logic [7:0]  m_bytes [$];
    logic [31:0] m_init;
    logic        m_inv;
    bit          m_in_frame = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [31:0] c;
            c = i;
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[i] = c;
        end
    end

    function automatic logic [31:0] model_crc();
        logic [31:0] c;
        c = m_init;
        foreach (m_bytes[i]) c = crc_tab[(c ^ {24'h0, m_bytes[i]}) & 32'hFF] ^ (c >> 8);
        return m_inv ? ~c : c;
    endfunction

    function automatic logic [LEN_W-1:0] model_len();
`ifdef IPPCRC_CTL_LEN_CNT_EN
        if (m_bytes.size() > (2**LEN_W - 1)) return '1;
        return LEN_W'(m_bytes.size());
`else
        return '0;
`endif
    endfunction

    // Scoreboard
    logic [31:0]      exp_q [$];
    logic [LEN_W-1:0] exp_len_q [$];
    int               exp_cyc_q [$];
    int               exp_err_q [$];

    // Driver: present a word at a negedge and hold it until in_rdy; model updates on acceptance
    task automatic send(input bit sop, input bit eop, input logic [1:0] nb, input logic [23:0] dat,
                        input logic [31:0] init, input bit inv, output int waited);
        int acc_cyc, nbe;
        @(negedge clk);
        in_vld = 1'b1; in_sop = sop; in_eop = eop; in_nb = nb; in_dat = dat;
        cfg_init = init; cfg_inv = inv;
        waited = 0;
        while (!in_rdy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_rdy) begin
            tests_run++; tests_failed++;
            $display("FAIL rdy_timeout: in_rdy=0 after %0d cycles, required 1", waited);
        end
        acc_cyc = cyc + 1;
        if (!m_in_frame && !sop) begin
            exp_err_q.push_back(acc_cyc);
        end else begin
            if (sop) begin
                if (m_in_frame) exp_err_q.push_back(acc_cyc);
                m_bytes.delete();
                m_init = init; m_inv = inv; m_in_frame = 1;
            end
            nbe = eop ? ((nb == 2'd0) ? 3 : int'(nb)) : 3;
            for (int k = 0; k < nbe; k++) m_bytes.push_back(dat[8*k +: 8]);
            if (eop) begin
                exp_q.push_back(model_crc());
                exp_len_q.push_back(model_len());
                exp_cyc_q.push_back(acc_cyc + ((nbe == 3) ? 0 : nbe));
                m_in_frame = 0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_vld = 1'b0; in_sop = $urandom_range(1); in_eop = $urandom_range(1);
            in_dat = $urandom;
        end
    endtask

    task automatic frame(input int nfull, input logic [1:0] nb, input logic [31:0] init, input bit inv);
        int w;
        for (int i = 0; i < nfull; i++)
            send(i == 0, 1'b0, 2'($urandom_range(3)), 24'($urandom), init, inv, w);
        send(nfull == 0, 1'b1, nb, 24'($urandom), init, inv, w);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_vld = 1'b0;
        #1;
        check("rst_rdy", 32'(in_rdy), 32'd1);
        check("rst_vld", 32'(out_vld), 32'd0);
        check("rst_crc", out_crc, 32'd0);
        check("rst_len", 32'(out_len), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        exp_q.delete(); exp_len_q.delete(); exp_cyc_q.delete(); exp_err_q.delete();
        m_in_frame = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && out_vld) begin
            if (exp_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL unexpected_vld: out_vld=1 at cycle %0d, required 0", cyc);
            end else begin
                check("crc", out_crc, exp_q.pop_front());
                check("len", 32'(out_len), 32'(exp_len_q.pop_front()));
                check("latency_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        if (rst_n && out_err) begin
            if (exp_err_q.size() == 0) begin
                tests_run++; tests_failed++;
                $display("FAIL unexpected_err: out_err=1 at cycle %0d, required 0", cyc);
            end else begin
                check("err_cycle", cyc, exp_err_q.pop_front());
            end
        end
    end

    initial begin
        int w;
        do_reset();
        idle(2);

        // 1: single word frame, bytes 01 02 03
        send(1, 1, 2'd3, 24'h030201, CRC32_INIT, 1'b1, w);
        idle(3);

        // Known answer: "123456789" -> CBF43926
        send(1, 0, 2'd0, 24'h333231, CRC32_INIT, 1'b1, w);
        send(0, 0, 2'd0, 24'h363534, CRC32_INIT, 1'b1, w);
        send(0, 1, 2'd3, 24'h393837, CRC32_INIT, 1'b1, w);
        exp_q[exp_q.size()-1] = 32'hCBF43926;
        idle(3);

        // 2: 4 full words + nb=2, next SOP waits exactly 2 cycles
        frame(4, 2'd2, CRC32_INIT, 1'b1);
        send(1, 1, 2'd3, 24'($urandom), CRC32_INIT, 1'b1, w);
        check("rdy_gap_nb2", w, 2);
        idle(3);

        // 3: nb=1 then immediate SOP, gap of 1
        frame(2, 2'd1, CRC32_INIT, 1'b0);
        send(1, 0, 2'd0, 24'($urandom), 32'h12345678, 1'b1, w);
        check("rdy_gap_nb1", w, 1);
        send(0, 1, 2'd2, 24'($urandom), 32'h0, 1'b0, w);
        send(1, 1, 2'd3, 24'($urandom), CRC32_INIT, 1'b1, w);
        check("rdy_gap_nb2_b2b", w, 2);
        send(1, 1, 2'd3, 24'($urandom), CRC32_INIT, 1'b0, w);
        check("rdy_gap_nb3_b2b", w, 0);
        idle(3);

        // 4: stray word in IDLE, then abort mid-frame
        send(0, 0, 2'd0, 24'hAABBCC, CRC32_INIT, 1'b1, w);
        send(1, 0, 2'd0, 24'h111111, CRC32_INIT, 1'b1, w);
        send(0, 0, 2'd0, 24'h222222, CRC32_INIT, 1'b1, w);
        frame(3, 2'd1, CRC32_INIT, 1'b1);
        idle(3);

        // 5: reset during TAIL
        send(1, 0, 2'd0, 24'h445566, CRC32_INIT, 1'b1, w);
        send(0, 1, 2'd2, 24'h778899, CRC32_INIT, 1'b1, w);
        do_reset();
        frame(2, 2'd2, CRC32_INIT, 1'b1);
        idle(4);

        // 6: nb=0 on EOP, nb=2 on a non-EOP word
        send(1, 0, 2'd2, 24'h5A5A5A, CRC32_INIT, 1'b1, w);
        send(0, 1, 2'd0, 24'hC3C3C3, CRC32_INIT, 1'b1, w);
        idle(3);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(7) == 0) send(0, 0, 2'd0, 24'($urandom), 32'h0, 1'b0, w);
            if ($urandom_range(7) == 0) begin
                send(1, 0, 2'd0, 24'($urandom), 32'($urandom), 1'b0, w);
                send(0, 0, 2'd0, 24'($urandom), 32'h0, 1'b0, w);
            end
            frame($urandom_range(6), 2'($urandom_range(3)),
                  ($urandom_range(1) != 0) ? CRC32_INIT : 32'($urandom), 1'($urandom_range(1)));
            idle($urandom_range(2));
        end

        idle(10);
        check("pending_vld", exp_q.size(), 0);
        check("pending_err", exp_err_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
